fetch_unit: RTL and testbench

Instruction fetch stage feeding the instruction decoder. It holds the program counter, issues one read at a time to instruction memory over a req/ack handshake, and presents the returned 32-bit word (`ins`) to the decoder with a valid/ready handshake. It accepts PC redirects for control-flow instructions (jal, jr, bleu) resolved downstream and discards any in-flight or held instruction from the old path.

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, keeps one read in flight
// to instruction memory at a time, and hands a registered instruction to the
// decoder over valid/ready. Redirects flush the held instruction; a redirect
// that lands on a pending read first drains that read at its original address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, FULL, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] tgt;

  // Redirect targets are word-aligned regardless of what the branch unit sends.
  assign tgt = {redirect_pc[31:2], 2'b00};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: redirect outranks ack and consume in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ: begin
        if (redirect)      state_nxt = imem_ack ? REQ : DRAIN;
        else if (imem_ack) state_nxt = FULL;
      end
      FULL:  if (redirect || ins_ready) state_nxt = REQ;
      DRAIN: if (imem_ack) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request outputs; a drain keeps presenting the stalled address.
  always_comb begin
    imem_req  = (state == REQ) || (state == DRAIN);
    imem_addr = (state == DRAIN) ? drain_addr : pc;
  end

  // PC, drain address and the decoder-facing instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      drain_addr <= 32'h0;
      ins        <= 32'h0;
      ins_pc     <= 32'h0;
      ins_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (redirect) pc <= tgt;
        REQ: begin
          if (redirect) begin
            // Returning data (if any) belongs to the old path and is dropped.
            pc <= tgt;
            if (!imem_ack) drain_addr <= pc;
          end else if (imem_ack) begin
            ins       <= imem_rdata;
            ins_pc    <= pc;
            ins_valid <= 1'b1;
            pc        <= pc + 32'd4;
          end
        end
        FULL: begin
          if (redirect) begin
            ins_valid <= 1'b0;
            pc        <= tgt;
          end else if (ins_ready) begin
            ins_valid <= 1'b0;
          end
        end
        DRAIN: if (redirect) pc <= tgt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: memory model answering addr^KEY after a programmable number
// of wait cycles, a consume-side scoreboard, a table of fetch vectors, and
// hand-written redirect / drain / reset sequences.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] ins, ins_pc;
  logic        ins_valid, ins_ready = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t        sb[$];
  logic [31:0] mlog[$];
  int          mem_waits = 0;
  int          mcnt = 0;
  logic [31:0] maddr = 32'h0;

  // Memory model: acks after mem_waits idle cycles, checks address stability.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !imem_req) begin
      imem_ack = 1'b0;
      mcnt = 0;
    end else begin
      if (mcnt == 0) maddr = imem_addr;
      else check("addr_stable", imem_addr, maddr);
      if (mcnt >= mem_waits) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ KEY;
        mlog.push_back(imem_addr);
        mcnt = 0;
      end else begin
        imem_ack = 1'b0;
        mcnt++;
      end
    end
  end

  // Consume monitor: every accepted instruction must match the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && ins_valid && ins_ready && !redirect) begin
      if (sb.size() == 0) check("unexpected_consume", ins_pc, 32'hDEAD_BEEF);
      else begin
        e = sb.pop_front();
        check("cons_pc", ins_pc, e.pc);
        check("cons_ins", ins, e.ins);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!ins_valid && n < 50) begin tick(); n++; end
    check({name, "_valid_timeout"}, {31'h0, ins_valid}, 32'h1);
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect = 1'b1; redirect_pc = t;
    tick();
    redirect = 1'b0;
  endtask

  // Reset mid-cycle, check async values, release and check first fetch timing.
  task automatic do_reset(input string name);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_rst_req"}, {31'h0, imem_req}, 32'h0);
    check({name, "_rst_addr"}, imem_addr, RST_PC);
    check({name, "_rst_valid"}, {31'h0, ins_valid}, 32'h0);
    check({name, "_rst_ins"}, ins, 32'h0);
    check({name, "_rst_inspc"}, ins_pc, 32'h0);
    mem_waits = 0;
    tick(); tick();
    #1 rst_n = 1'b1;
    @(negedge clk);
    check({name, "_idle_no_req"}, {31'h0, imem_req}, 32'h0);
    tick();
    check({name, "_first_req"}, {31'h0, imem_req}, 32'h1);
    check({name, "_first_addr"}, imem_addr, RST_PC);
    tick();
    check({name, "_first_valid"}, {31'h0, ins_valid}, 32'h1);
    check({name, "_first_pc"}, ins_pc, RST_PC);
    check({name, "_first_ins"}, ins, RST_PC ^ KEY);
  endtask

  typedef struct { logic [31:0] tgt; int waits; int hold; int cnt; } vec_t;

  initial begin
    vec_t        vt[4];
    logic [31:0] p, held, t;

    vt[0] = '{32'h0000_0200, 3, 5, 2};
    vt[1] = '{32'h0000_0307, 2, 2, 2};
    vt[2] = '{32'hFFFF_FFFC, 0, 1, 3};
    vt[3] = '{32'h1234_5678, 1, 0, 2};

    tick();
    do_reset("por");

    // Zero-wait, ready high: 0,4,8,C with valid toggling every cycle.
    mem_waits = 0;
    redirect_to(32'h0);
    ins_ready = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back('{32'(k * 4), 32'(k * 4) ^ KEY});
    for (int i = 0; i < 8; i++) begin
      check("toggle_valid", {31'h0, ins_valid}, 32'(i % 2));
      tick();
    end
    ins_ready = 1'b0;
    check("tput_sb_empty", 32'(sb.size()), 32'h0);

    // Table vectors: redirect, wait states, hold-off before consume.
    for (int v = 0; v < 4; v++) begin
      mem_waits = vt[v].waits;
      redirect_to(vt[v].tgt);
      p = {vt[v].tgt[31:2], 2'b00};
      for (int k = 0; k < vt[v].cnt; k++) begin
        sb.push_back('{p, p ^ KEY});
        p = p + 32'd4;
      end
      for (int k = 0; k < vt[v].cnt; k++) begin
        wait_valid("vec");
        held = ins;
        for (int h = 0; h < vt[v].hold; h++) begin
          check("hold_no_req", {31'h0, imem_req}, 32'h0);
          check("hold_stable", ins, held);
          tick();
        end
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
      end
      check("vec_sb_empty", 32'(sb.size()), 32'h0);
    end

    // Redirect in FULL together with ins_ready: flush, refetch at 0x100.
    mem_waits = 0;
    wait_valid("pre_flush");
    redirect = 1'b1; redirect_pc = 32'h0000_0103; ins_ready = 1'b1;
    tick();
    redirect = 1'b0; ins_ready = 1'b0;
    check("flush_valid", {31'h0, ins_valid}, 32'h0);
    check("flush_req", {31'h0, imem_req}, 32'h1);
    check("flush_addr", imem_addr, 32'h100);
    tick();
    check("flush_next_valid", {31'h0, ins_valid}, 32'h1);
    check("flush_next_pc", ins_pc, 32'h100);
    check("flush_next_ins", ins, 32'h100 ^ KEY);

    // Redirect during a 2-wait read at 0x8; second pass re-redirects in DRAIN.
    for (int s = 0; s < 2; s++) begin
      wait_valid("pre_drain");
      mem_waits = 2;
      mlog.delete();
      redirect_to(32'h8);
      check("drain_req_addr", imem_addr, 32'h8);
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      if (s == 1) begin
        redirect_pc = 32'h80;
        tick();
      end
      redirect = 1'b0;
      t = (s == 1) ? 32'h80 : 32'h40;
      check("drain_addr", imem_addr, 32'h8);
      check("drain_valid", {31'h0, ins_valid}, 32'h0);
      wait_valid("drain");
      check("drain_tgt_pc", ins_pc, t);
      check("drain_tgt_ins", ins, t ^ KEY);
      check("drain_log_len", 32'(mlog.size()), 32'h2);
      if (mlog.size() == 2) begin
        check("drain_log0", mlog[0], 32'h8);
        check("drain_log1", mlog[1], t);
      end
    end

    // Reset while a read is waiting for ack.
    wait_valid("pre_rst");
    mem_waits = 3;
    redirect_to(32'h500);
    check("pre_rst_req", {31'h0, imem_req}, 32'h1);
    do_reset("mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
